// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_IDLE  = 1'b1
    } fsm_state_e;

    localparam int unsigned MAX_RD_PORTS = 4;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Scrub sequencer: walks every register index once after reset or on request,
// then reports the file ready.
module regfile_scrub_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned AW = addr_width(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          ready,
    output logic          scrub_en,
    output logic [AW-1:0] scrub_idx
);

    fsm_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_SCRUB: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NUM_REGS - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_SCRUB;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_SCRUB;
                idx_d   = '0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SCRUB;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign scrub_en  = (state_q == ST_SCRUB);
    assign scrub_idx = idx_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file with pending scoreboard and scrub-based clear.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned ZERO_REG     = 1,
    localparam int unsigned AW = addr_width(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear_req,
    output logic                         ready,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [XLEN-1:0]              wr_data,
    input  logic                         claim_en,
    input  logic [AW-1:0]                claim_addr,
    input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
    output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]      rd_pending
);

    logic [XLEN-1:0]     mem [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                scrub_en;
    logic [AW-1:0]       scrub_idx;
    logic                wr_ok, claim_ok;

    regfile_scrub_fsm #(
        .NUM_REGS (NUM_REGS)
    ) u_scrub (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .ready     (ready),
        .scrub_en  (scrub_en),
        .scrub_idx (scrub_idx)
    );

    assign wr_ok    = ready && wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign claim_ok = ready && claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

    // Array has no reset; the scrub sequence is its only clear path.
    always_ff @(posedge clock) begin
        if (scrub_en) begin
            mem[scrub_idx] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Claim is applied after the write so it wins on the same address.
    always_comb begin
        pending_d = pending_q;
        if (ready && clear_req) begin
            pending_d = '0;
        end else begin
            if (wr_ok)    pending_d[wr_addr]    = 1'b0;
            if (claim_ok) pending_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            logic            pd;
            a  = rd_addr[p*AW +: AW];
            d  = mem[a];
            pd = pending_q[a];
            if ((ZERO_REG != 0) && (a == '0)) d = '0;
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == a)) begin
                d  = wr_data;
                pd = claim_ok && (claim_addr == wr_addr);
            end
`endif
            if (ready) begin
                rd_data[p*XLEN +: XLEN] = d;
                rd_pending[p]           = pd;
            end
        end
    end

endmodule
